// File: rtl/mem_lsu_pipe.sv
// Load/store unit: in-order tracking queue of up to MAX_OUTSTANDING memory ops, store lane
// shaping and load alignment/extension. Issue is combinational; writeback is registered one
// cycle after the response. Backpressure: req_ready drops when the queue is full, on flush,
// or while mem_req_ready is low. Optional misaligned-access trap under LSU_MISALIGN_TRAP_EN.
module mem_lsu_pipe #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_load,
    input  logic                    req_is_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    input  logic                    flush,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDR_WIDTH-1:0]   mem_req_index,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
    output logic                    wb_valid,
    output logic                    wb_is_load,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic [TAG_WIDTH-1:0]    wb_tag,
    output logic                    wb_exception,
    output logic                    lsu_busy
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PTRW = $clog2(MAX_OUTSTANDING);
    localparam int CNTW = PTRW + 1;

    typedef struct packed {
        logic                 is_load;
        logic [1:0]           size;
        logic                 uns;
        logic [OFFW-1:0]      off;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t                     q_mem [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] killed;
    logic [PTRW-1:0]            head;
    logic [PTRW-1:0]            tail;
    logic [CNTW-1:0]            count;

    logic            is_op;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [OFFW-1:0] req_off;
    entry_t          head_e;
    logic [DATA_WIDTH-1:0] load_shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [NB-1:0]         mask_base;
    logic [2*NB-1:0]       mask_wide;

    assign is_op   = req_is_load | req_is_store;
    assign full    = (count == CNTW'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign req_off = req_addr[OFFW-1:0];
    assign pop     = mem_resp_valid & ~empty;
    assign head_e  = q_mem[head];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic mis_op;
    logic trap_fire;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            2'd3:    misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign mis_op = is_op & misalign;
    // A trapping op waits for the queue to drain so its exception stays in program order.
    assign req_ready     = ~full & ~flush & (mis_op ? (empty & ~mem_resp_valid) : mem_req_ready);
    assign mem_req_valid = req_valid & is_op & ~full & ~flush & ~misalign;
    assign trap_fire     = req_valid & mis_op & req_ready;
`else
    assign req_ready     = ~full & ~flush & mem_req_ready;
    assign mem_req_valid = req_valid & is_op & ~full & ~flush;
    assign wb_exception  = 1'b0;
`endif

    assign push = mem_req_valid & mem_req_ready;

    always_comb begin
        mask_base = '0;
        case (req_size)
            2'd0:    mask_base = NB'(8'h01);
            2'd1:    mask_base = NB'(8'h03);
            2'd2:    mask_base = NB'(8'h0F);
            default: mask_base = NB'(8'hFF);
        endcase
    end

    // Lanes shifted past the top of the word fall off when truncating back to NB bits.
    assign mask_wide     = {{NB{1'b0}}, mask_base} << req_off;
    assign mem_req_wmask = mask_wide[NB-1:0];
    assign mem_req_wdata = req_wdata << {req_off, 3'b000};
    assign mem_req_index = req_addr >> OFFW;
    assign mem_req_write = req_is_store;

    assign lsu_busy = (~empty & ~((count == CNTW'(1)) & mem_resp_valid))
                    | (req_valid & is_op & ~req_ready);

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] sh,
                                                          input logic [1:0] sz,
                                                          input logic uns);
        logic [DATA_WIDTH-1:0] res;
        logic                  sgn;
        int                    bits;
        bits = 8 << sz;
        case (sz)
            2'd0:    sgn = sh[7];
            2'd1:    sgn = sh[15];
            2'd2:    sgn = sh[31];
            default: sgn = sh[DATA_WIDTH-1];
        endcase
        sgn = sgn & ~uns;
        res = sh;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= bits) res[i] = sgn;
        end
        return res;
    endfunction

    assign load_shifted = mem_resp_rdata >> {head_e.off, 3'b000};
    assign load_ext     = extend_load(load_shifted, head_e.size, head_e.uns);

    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[tail] <= '{is_load: req_is_load, size: req_size, uns: req_unsigned,
                             off: req_off, tag: req_tag};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            killed <= '0;
        end else begin
            if (push) tail <= tail + PTRW'(1);
            if (pop)  head <= head + PTRW'(1);
            count <= count + CNTW'(push) - CNTW'(pop);
            // Stale kill bits on free slots are harmless: a push always clears its slot.
            if (flush) killed <= '1;
            if (push)  killed[tail] <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            wb_is_load <= 1'b0;
            wb_data    <= '0;
            wb_tag     <= '0;
        end else begin
            wb_valid <= pop & ~killed[head] & ~flush;
            if (pop) begin
                wb_is_load <= head_e.is_load;
                wb_tag     <= head_e.tag;
                wb_data    <= head_e.is_load ? load_ext : '0;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            if (trap_fire) begin
                wb_valid   <= 1'b1;
                wb_is_load <= req_is_load;
                wb_tag     <= req_tag;
                wb_data    <= DATA_WIDTH'(req_addr);
            end
`endif
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wb_exception <= 1'b0;
        else       wb_exception <= trap_fire;
    end
`endif

endmodule

// File: tb/tb_mem_lsu_pipe.sv
// Bench for mem_lsu_pipe: directed ops against a queue-based reference model, plus
// hand-computed literal expectations for the key scenarios.
module tb_mem_lsu_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_load, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        flush;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_index, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid, wb_is_load, wb_exception, lsu_busy;
    logic [63:0] wb_data;
    logic [4:0]  wb_tag;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_lsu_pipe dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_index(mem_req_index),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_exception(wb_exception), .lsu_busy(lsu_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [4:0]  tag;
        logic        killed;
    } ent_t;

    ent_t        q[$];
    logic        exp_vld = 1'b0;
    logic        exp_ld = 1'b0;
    logic [63:0] exp_data = '0;
    logic [4:0]  exp_tag = '0;

    function automatic logic [63:0] load_val(input logic [63:0] rd, input int off,
                                             input logic [1:0] sz, input logic uns);
        logic [63:0] sh, m, v;
        int n;
        sh = rd >> (8 * off);
        n  = 8 << sz;
        if (n == 64) return sh;
        m = (64'd1 << n) - 64'd1;
        v = sh & m;
        if (!uns && sh[n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [7:0] lane_mask(input int off, input logic [1:0] sz);
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + (1 << sz));
        return m;
    endfunction

    always @(posedge clock) begin
        int   n;
        ent_t e;
        exp_vld = 1'b0;
        if (reset) begin
            q.delete();
        end else begin
            n = q.size();
            if (mem_resp_valid && n > 0) begin
                e = q.pop_front();
                if (!e.killed && !flush) begin
                    exp_vld  = 1'b1;
                    exp_ld   = e.is_load;
                    exp_tag  = e.tag;
                    exp_data = e.is_load ? load_val(mem_resp_rdata, int'(e.addr[2:0]), e.size, e.uns) : 64'd0;
                end
            end
            if (flush) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    e.killed = 1'b1;
                    q[i] = e;
                end
            end
            if (req_valid && (req_is_load || req_is_store) && n < 4 && !flush && mem_req_ready)
                q.push_back('{req_is_load, req_size, req_unsigned, req_addr, req_tag, 1'b0});
        end
    end

    always @(negedge clock) begin
        int   cnt;
        logic op, rdy, mv, busy;
        if (!reset) begin
            cnt  = q.size();
            op   = req_is_load || req_is_store;
            rdy  = (cnt < 4) && !flush && mem_req_ready;
            mv   = req_valid && op && (cnt < 4) && !flush;
            busy = ((cnt != 0) && !((cnt == 1) && mem_resp_valid)) || (req_valid && op && !rdy);
            check("req_ready", req_ready, rdy);
            check("mem_req_valid", mem_req_valid, mv);
            check("lsu_busy", lsu_busy, busy);
            if (mv) begin
                check("mem_req_index", mem_req_index, req_addr >> 3);
                check("mem_req_wmask", mem_req_wmask, lane_mask(int'(req_addr[2:0]), req_size));
                check("mem_req_wdata", mem_req_wdata, req_wdata << (8 * req_addr[2:0]));
                check("mem_req_write", mem_req_write, req_is_store);
            end
            check("wb_valid", wb_valid, exp_vld);
            if (exp_vld) begin
                check("wb_is_load", wb_is_load, exp_ld);
                check("wb_tag", wb_tag, exp_tag);
                check("wb_data", wb_data, exp_data);
            end
            check("wb_exception", wb_exception, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] tag);
        req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd; req_tag = tag;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    endtask

    task automatic req_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] tag);
        drive(ld, st, sz, uns, addr, wd, tag);
        tick();
        idle_req();
    endtask

    task automatic resp(input logic [63:0] rd);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = '0; req_size = '0; req_unsigned = 1'b0; req_addr = '0;
        req_wdata = '0; req_tag = '0;
        idle_req();
        #3;
        check("rst wb_valid", wb_valid, 1'b0);
        check("rst wb_is_load", wb_is_load, 1'b0);
        check("rst wb_data", wb_data, 64'd0);
        check("rst wb_tag", wb_tag, 5'd0);
        check("rst wb_exception", wb_exception, 1'b0);
        check("rst lsu_busy", lsu_busy, 1'b0);
        mem_req_ready = 1'b1;
        #1;
        check("rst req_ready", req_ready, 1'b1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Store byte with lane shift
        drive(1'b0, 1'b1, 2'd0, 1'b0, 64'h1003, 64'hAB, 5'd1);
        #2;
        check("sb index", mem_req_index, 64'h200);
        check("sb wmask", mem_req_wmask, 8'h08);
        check("sb wdata", mem_req_wdata, 64'hAB00_0000);
        tick(); idle_req(); tick();
        resp(64'hDEAD_BEEF_0000_1111);
        check("sb wb_valid", wb_valid, 1'b1);
        check("sb wb_is_load", wb_is_load, 1'b0);
        check("sb wb_data", wb_data, 64'd0);
        check("sb wb_tag", wb_tag, 5'd1);
        tick();
        check("sb wb pulse", wb_valid, 1'b0);

        // Halfword loads, signed then unsigned
        req_op(1'b1, 1'b0, 2'd1, 1'b0, 64'h2006, 64'd0, 5'd2);
        resp(64'h8001_0000_0000_0000);
        check("lh signed", wb_data, 64'hFFFF_FFFF_FFFF_8001);
        req_op(1'b1, 1'b0, 2'd1, 1'b1, 64'h2006, 64'd0, 5'd3);
        resp(64'h8001_0000_0000_0000);
        check("lhu", wb_data, 64'h8001);
        req_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h3001, 64'd0, 5'd4);
        resp(64'h8000);
        check("lb signed", wb_data, 64'hFFFF_FFFF_FFFF_FF80);

        // Store word at offset 4, and a misaligned word whose upper lanes drop
        drive(1'b0, 1'b1, 2'd2, 1'b0, 64'h1004, 64'h1234_5678, 5'd5);
        #2;
        check("sw wmask", mem_req_wmask, 8'hF0);
        check("sw wdata", mem_req_wdata, 64'h1234_5678_0000_0000);
        tick(); idle_req();
        resp(64'd0);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 64'h1006, 64'h1234_5678, 5'd6);
        #2;
        check("sw drop wmask", mem_req_wmask, 8'hC0);
        tick(); idle_req();
        resp(64'd0);

        // Size/offset sweep checked by the model
        for (int i = 0; i < 16; i++) begin
            req_op(1'b1, 1'b0, 2'(i % 4), 1'(i / 8), 64'h4000 + 64'(i * 3 % 8), 64'd0, 5'(i));
            resp(64'hF1E2_D3C4_B5A6_9788);
            req_op(1'b0, 1'b1, 2'(i % 4), 1'b0, 64'h5000 + 64'(i % 8), 64'hCAFE_F00D_1234_5678, 5'(i + 16));
            resp(64'd0);
        end

        // Fill the queue: fifth op stalls until a response frees a slot
        for (int i = 0; i < 4; i++) req_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h100 + 64'(8 * i), 64'd0, 5'(10 + i));
        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h120, 64'd0, 5'd14);
        #2;
        check("full req_ready", req_ready, 1'b0);
        check("full lsu_busy", lsu_busy, 1'b1);
        check("full mem_req_valid", mem_req_valid, 1'b0);
        tick();
        resp(64'h11);
        check("full first tag", wb_tag, 5'd10);
        #2;
        check("freed req_ready", req_ready, 1'b1);
        tick(); idle_req();
        for (int i = 0; i < 4; i++) begin
            resp(64'h22 + 64'(i));
            check("inorder tag", wb_tag, 5'(11 + i));
        end

        // Flush kills in-flight ops
        for (int i = 0; i < 3; i++) req_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h200 + 64'(8 * i), 64'd0, 5'(20 + i));
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp(64'h33);
            check("killed no wb", wb_valid, 1'b0);
        end
        req_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h300, 64'd0, 5'd23);
        resp(64'h0000_0000_7654_3210);
        check("post flush wb", wb_valid, 1'b1);
        check("post flush tag", wb_tag, 5'd23);
        check("post flush data", wb_data, 64'h7654_3210);

        // Flush coinciding with a pop
        req_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h400, 64'd0, 5'd24);
        req_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h408, 64'd0, 5'd25);
        flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h44;
        tick();
        flush = 1'b0; mem_resp_valid = 1'b0;
        check("flush+pop no wb", wb_valid, 1'b0);
        resp(64'h55);
        check("flush+pop tail no wb", wb_valid, 1'b0);

        // Memory backpressure
        mem_req_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd3, 1'b0, 64'h500, 64'd0, 5'd26);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp req_ready", req_ready, 1'b0);
            check("bp lsu_busy", lsu_busy, 1'b1);
            tick();
        end
        mem_req_ready = 1'b1;
        #2;
        check("bp release", req_ready, 1'b1);
        tick(); idle_req();
        resp(64'h66);
        check("bp tag", wb_tag, 5'd26);

        // Non-memory op and stray response
        drive(1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'd0, 5'd27);
        #2;
        check("nop req_ready", req_ready, 1'b1);
        check("nop mem_req_valid", mem_req_valid, 1'b0);
        check("nop lsu_busy", lsu_busy, 1'b0);
        tick(); idle_req();
        resp(64'h77);
        check("empty resp", wb_valid, 1'b0);

        // Reset with ops in flight
        req_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h600, 64'd0, 5'd28);
        req_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h608, 64'd0, 5'd29);
        reset = 1'b1;
        #2;
        check("midrst lsu_busy", lsu_busy, 1'b0);
        tick(); tick();
        reset = 1'b0;
        tick();
        resp(64'h88);
        check("after rst resp", wb_valid, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
